// File: rtl/frog_game_sequencer.sv
// Frogger game-flow controller: sequences IDLE/PLAY/DYING/LEVEL_CLEAR/GAME_OVER
// and keeps level, lives, score and the per-life frame timer.
module frog_game_sequencer #(
    parameter int NUM_LIVES    = 3,
    parameter int MAX_LEVEL    = 9,
    parameter int ROUND_FRAMES = 1800,
    parameter int DEATH_FRAMES = 60,
    parameter int CLEAR_FRAMES = 120,
    parameter int HOME_POINTS  = 10,
    parameter int LEVEL_POINTS = 100
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk_rising_edge,
    input  logic        start_key,
    input  logic        frog_hit,
    input  logic        frog_home,
    input  logic        GoNextLevel,
    output logic [2:0]  game_state,
    output logic        ResetGame,
    output logic        ResetFrog,
    output logic        freeze,
    output logic [3:0]  Level,
    output logic [2:0]  Lives,
    output logic [10:0] TimeLeft,
    output logic [15:0] Score
);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] PLAY        = 3'd1;
    localparam logic [2:0] DYING       = 3'd2;
    localparam logic [2:0] LEVEL_CLEAR = 3'd3;
    localparam logic [2:0] GAME_OVER   = 3'd4;

    localparam logic [2:0]  LIVES_INIT = 3'(NUM_LIVES);
    localparam logic [3:0]  LEVEL_MAX  = 4'(MAX_LEVEL);
    localparam logic [10:0] ROUND_T    = 11'(ROUND_FRAMES);
    localparam logic [10:0] DEATH_T    = 11'(DEATH_FRAMES);
    localparam logic [10:0] CLEAR_T    = 11'(CLEAR_FRAMES);
    localparam logic [16:0] HOME_P     = 17'(HOME_POINTS);
    localparam logic [16:0] LEVEL_P    = 17'(LEVEL_POINTS);

    logic        startQ;
    logic [10:0] frameCnt;

    logic [2:0]  stateN;
    logic [3:0]  levelN;
    logic [2:0]  livesN;
    logic [10:0] timeN;
    logic [15:0] scoreN;
    logic [10:0] cntN;
    logic        resetGameN;
    logic        resetFrogN;

    logic        startEdge;
    logic        timeout;
    logic [16:0] scoreSum;

    assign startEdge = start_key & ~startQ;
    assign timeout   = frame_clk_rising_edge && (TimeLeft == 11'd1);
    // Home and level bonuses land in the same cycle; one extra bit catches overflow.
    assign scoreSum  = {1'b0, Score} + (frog_home ? HOME_P : 17'd0)
                     + (GoNextLevel ? LEVEL_P : 17'd0);

    always_comb begin
        stateN     = game_state;
        levelN     = Level;
        livesN     = Lives;
        timeN      = TimeLeft;
        scoreN     = Score;
        cntN       = frameCnt;
        resetGameN = 1'b0;
        resetFrogN = 1'b0;
        case (game_state)
            IDLE, GAME_OVER: begin
                if (startEdge) begin
                    stateN     = PLAY;
                    levelN     = 4'd1;
                    livesN     = LIVES_INIT;
                    scoreN     = 16'd0;
                    timeN      = ROUND_T;
                    resetGameN = 1'b1;
                    resetFrogN = 1'b1;
                end
            end
            PLAY: begin
                scoreN = scoreSum[16] ? 16'hFFFF : scoreSum[15:0];
                if (GoNextLevel) begin
                    stateN = LEVEL_CLEAR;
                    cntN   = CLEAR_T;
                    if (Level < LEVEL_MAX) levelN = Level + 4'd1;
                end else if (frog_hit || timeout) begin
                    stateN = DYING;
                    cntN   = DEATH_T;
                    if (Lives != 3'd0) livesN = Lives - 3'd1;
                    if (timeout) timeN = 11'd0;
                end else if (frame_clk_rising_edge) begin
                    timeN = TimeLeft - 11'd1;
                end
            end
            DYING: begin
                if (frame_clk_rising_edge) begin
                    if (frameCnt == 11'd1) begin
                        if (Lives == 3'd0) begin
                            stateN = GAME_OVER;
                        end else begin
                            stateN     = PLAY;
                            timeN      = ROUND_T;
                            resetFrogN = 1'b1;
                        end
                    end else begin
                        cntN = frameCnt - 11'd1;
                    end
                end
            end
            LEVEL_CLEAR: begin
                if (frame_clk_rising_edge) begin
                    if (frameCnt == 11'd1) begin
                        stateN     = PLAY;
                        timeN      = ROUND_T;
                        resetFrogN = 1'b1;
                        resetGameN = 1'b1;
                    end else begin
                        cntN = frameCnt - 11'd1;
                    end
                end
            end
            default: stateN = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            game_state <= IDLE;
            ResetGame  <= 1'b0;
            ResetFrog  <= 1'b0;
            freeze     <= 1'b1;
            Level      <= 4'd1;
            Lives      <= LIVES_INIT;
            TimeLeft   <= ROUND_T;
            Score      <= 16'd0;
            frameCnt   <= 11'd0;
            startQ     <= 1'b0;
        end else begin
            game_state <= stateN;
            ResetGame  <= resetGameN;
            ResetFrog  <= resetFrogN;
            freeze     <= (stateN != PLAY);
            Level      <= levelN;
            Lives      <= livesN;
            TimeLeft   <= timeN;
            Score      <= scoreN;
            frameCnt   <= cntN;
            startQ     <= start_key;
        end
    end

endmodule
